// File: rtl/controle_multiciclo_if.sv
// Control bus between the multicycle sequencer (master) and the datapath / IO side (slave).
interface controle_multiciclo_if #(
  parameter int INSTR_W = 16
);
  logic [3:0]         opcode;
  logic               zero;
  logic               step_mode;
  logic               step_req;
  logic               esc_ir;
  logic               esc_cp;
  logic               esc_cond_cp;
  logic [1:0]         fonte_cp;
  logic               ula_a;
  logic [1:0]         ula_b;
  logic [3:0]         ula_op;
  logic               esc_reg;
  logic               flag_imm;
  logic               halted;
  logic [2:0]         estado;
  logic [INSTR_W-1:0] instr_count;

  modport master (
    input  opcode, zero, step_mode, step_req,
    output esc_ir, esc_cp, esc_cond_cp, fonte_cp, ula_a, ula_b, ula_op,
           esc_reg, flag_imm, halted, estado, instr_count
  );

  modport slave (
    output opcode, zero, step_mode, step_req,
    input  esc_ir, esc_cp, esc_cond_cp, fonte_cp, ula_a, ula_b, ula_op,
           esc_reg, flag_imm, halted, estado, instr_count
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the 16-bit processor: sequences IR/PC/ALU/register-bank controls
// from the opcode, with free-run / single-step execution, halt and a retired-instruction counter.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting: free-run starts at once, single-step waits for a step_req edge
// S_FETCH  | IR <= mem[PC], PC <= PC + 1
// S_DECODE | latch opcode, precompute branch target, dispatch
// S_EXEC_R | register-register ALU op
// S_EXEC_I | register-immediate ALU op
// S_WB     | register bank write, ALU controls held from EXEC
// S_BRANCH | compare, PC <= target if zero
// S_JUMP   | PC <= IR[11:0]
// S_HALT   | stopped until reset
module controle_multiciclo #(
  parameter int INSTR_W   = 16,
  parameter int OP_BRANCH = 11,
  parameter int OP_JUMP   = 12,
  parameter int OP_HALT   = 15
) (
  input logic                   CLOCK_50,
  input logic                   reset,
  controle_multiciclo_if.master bus
);

  localparam logic [3:0] OPC_BRANCH = 4'(OP_BRANCH);
  localparam logic [3:0] OPC_JUMP   = 4'(OP_JUMP);
  localparam logic [3:0] OPC_HALT   = 4'(OP_HALT);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_WB     = 4'd5,
    S_BRANCH = 4'd6,
    S_JUMP   = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  state_t             state, state_nxt;
  logic [3:0]         opcode_q;
  logic [INSTR_W-1:0] instr_count;
  logic               step_q;
  logic               step_edge;
  logic               retire;
  logic               op_is_itype;
  state_t             after_done;

  assign step_edge   = bus.step_req & ~step_q;
  assign op_is_itype = (opcode_q >= 4'd6) && (opcode_q <= 4'd10);
  assign after_done  = bus.step_mode ? S_IDLE : S_FETCH;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= S_IDLE;
      opcode_q    <= '0;
      instr_count <= '0;
      step_q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      step_q <= bus.step_req;
      if (state == S_DECODE) opcode_q <= bus.opcode;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.step_mode || step_edge) state_nxt = S_FETCH;
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        if (bus.opcode <= 4'd5)            state_nxt = S_EXEC_R;
        else if (bus.opcode <= 4'd10)      state_nxt = S_EXEC_I;
        else if (bus.opcode == OPC_BRANCH) state_nxt = S_BRANCH;
        else if (bus.opcode == OPC_JUMP)   state_nxt = S_JUMP;
        else if (bus.opcode == OPC_HALT)   state_nxt = S_HALT;
        else begin
          retire    = 1'b1;
          state_nxt = after_done;
        end
      end
      S_EXEC_R: state_nxt = S_WB;
      S_EXEC_I: state_nxt = S_WB;
      S_WB, S_BRANCH, S_JUMP: begin
        retire    = 1'b1;
        state_nxt = after_done;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are masked while reset is high so a reset landing in WB/FETCH cannot leak a write pulse.
  always_comb begin
    bus.esc_ir      = 1'b0;
    bus.esc_cp      = 1'b0;
    bus.esc_cond_cp = 1'b0;
    bus.fonte_cp    = 2'd0;
    bus.ula_a       = 1'b0;
    bus.ula_b       = 2'd0;
    bus.ula_op      = 4'd0;
    bus.esc_reg     = 1'b0;
    bus.flag_imm    = 1'b0;
    bus.halted      = 1'b0;
    bus.estado      = 3'd0;
    bus.instr_count = instr_count;
    if (!reset) begin
      bus.estado = (state == S_HALT) ? 3'd7 : state[2:0];
      case (state)
        S_FETCH: begin
          bus.esc_ir = 1'b1;
          bus.esc_cp = 1'b1;
          bus.ula_b  = 2'd1;
        end
        S_DECODE: bus.ula_b = 2'd2;
        S_EXEC_R: begin
          bus.ula_a  = 1'b1;
          bus.ula_op = opcode_q;
        end
        S_EXEC_I: begin
          bus.ula_a    = 1'b1;
          bus.ula_b    = 2'd2;
          bus.ula_op   = opcode_q;
          bus.flag_imm = 1'b1;
        end
        S_WB: begin
          bus.esc_reg  = 1'b1;
          bus.ula_a    = 1'b1;
          bus.ula_op   = opcode_q;
          bus.ula_b    = op_is_itype ? 2'd2 : 2'd0;
          bus.flag_imm = op_is_itype;
        end
        S_BRANCH: begin
          bus.ula_a       = 1'b1;
          bus.ula_op      = 4'd1;
          bus.esc_cond_cp = 1'b1;
          bus.fonte_cp    = 2'd1;
        end
        S_JUMP: begin
          bus.esc_cp   = 1'b1;
          bus.fonte_cp = 2'd2;
        end
        S_HALT:  bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: free-run, branch/jump/NOP/halt, single-step, reset in WB
// and counter wrap (on a second instance with a 2-bit counter).
module tb_controle_multiciclo;
  logic CLOCK_50;
  logic reset;
  int   checks;
  int   errors;

  controle_multiciclo_if #(.INSTR_W(16)) b ();
  controle_multiciclo_if #(.INSTR_W(2))  bs ();

  controle_multiciclo #(.INSTR_W(16)) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (b)
  );

  controle_multiciclo #(.INSTR_W(2)) dut_small (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bs)
  );

  assign bs.opcode    = b.opcode;
  assign bs.zero      = b.zero;
  assign bs.step_mode = b.step_mode;
  assign bs.step_req  = b.step_req;

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    b.opcode    = 4'd0;
    b.zero      = 1'b0;
    b.step_mode = 1'b0;
    b.step_req  = 1'b0;
    tick();
    tick();
    chk("rst_estado", 32'(b.estado), 0);
    chk("rst_count", 32'(b.instr_count), 0);
    chk("rst_esc_ir", 32'(b.esc_ir), 0);

    // free-run: opcode 0 (R) then 6 (I)
    reset = 1'b0;
    tick();
    chk("f_estado", 32'(b.estado), 1);
    chk("f_esc_ir", 32'(b.esc_ir), 1);
    chk("f_esc_cp", 32'(b.esc_cp), 1);
    chk("f_ula_b", 32'(b.ula_b), 1);
    tick();
    chk("d_estado", 32'(b.estado), 2);
    chk("d_ula_b", 32'(b.ula_b), 2);
    tick();
    chk("er_estado", 32'(b.estado), 3);
    chk("er_ula_op", 32'(b.ula_op), 0);
    chk("er_ula_b", 32'(b.ula_b), 0);
    chk("er_ula_a", 32'(b.ula_a), 1);
    b.opcode = 4'd6;
    tick();
    chk("wb_estado", 32'(b.estado), 5);
    chk("wb_esc_reg", 32'(b.esc_reg), 1);
    chk("wb_flag_imm_r", 32'(b.flag_imm), 0);
    tick();
    chk("f2_estado", 32'(b.estado), 1);
    chk("count_1", 32'(b.instr_count), 1);
    tick();
    tick();
    chk("ei_estado", 32'(b.estado), 4);
    chk("ei_flag_imm", 32'(b.flag_imm), 1);
    chk("ei_ula_b", 32'(b.ula_b), 2);
    chk("ei_ula_op", 32'(b.ula_op), 6);
    tick();
    chk("wbi_esc_reg", 32'(b.esc_reg), 1);
    chk("wbi_flag_imm", 32'(b.flag_imm), 1);
    chk("wbi_ula_op", 32'(b.ula_op), 6);
    tick();
    chk("count_2", 32'(b.instr_count), 2);
    chk("f3_estado", 32'(b.estado), 1);

    // branch taken then not taken
    b.opcode = 4'd11;
    b.zero   = 1'b1;
    tick();
    tick();
    chk("br_estado", 32'(b.estado), 6);
    chk("br_cond", 32'(b.esc_cond_cp), 1);
    chk("br_fonte", 32'(b.fonte_cp), 1);
    chk("br_ula_op", 32'(b.ula_op), 1);
    tick();
    chk("br_after", 32'(b.estado), 1);
    chk("br_cond_off", 32'(b.esc_cond_cp), 0);
    chk("count_3", 32'(b.instr_count), 3);
    b.zero = 1'b0;
    tick();
    tick();
    chk("br0_estado", 32'(b.estado), 6);
    tick();
    chk("br0_after", 32'(b.estado), 1);
    chk("count_4", 32'(b.instr_count), 4);

    // jump, NOP, halt
    b.opcode = 4'd12;
    tick();
    tick();
    chk("j_estado", 32'(b.estado), 7);
    chk("j_esc_cp", 32'(b.esc_cp), 1);
    chk("j_fonte", 32'(b.fonte_cp), 2);
    chk("j_halted", 32'(b.halted), 0);
    tick();
    chk("count_5", 32'(b.instr_count), 5);
    b.opcode = 4'd13;
    tick();
    chk("nop_dec", 32'(b.estado), 2);
    tick();
    chk("nop_fetch", 32'(b.estado), 1);
    chk("count_6", 32'(b.instr_count), 6);
    b.opcode = 4'd15;
    tick();
    tick();
    chk("h_estado", 32'(b.estado), 7);
    chk("h_halted", 32'(b.halted), 1);
    chk("h_esc_cp", 32'(b.esc_cp), 0);
    b.step_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b.step_req = ~b.step_req;
      tick();
    end
    b.step_mode = 1'b0;
    tick();
    chk("h_stay", 32'(b.halted), 1);
    chk("h_esc_ir", 32'(b.esc_ir), 0);
    chk("h_count", 32'(b.instr_count), 6);
    reset = 1'b1;
    tick();
    chk("h_rst_estado", 32'(b.estado), 0);
    chk("h_rst_halted", 32'(b.halted), 0);
    chk("h_rst_count", 32'(b.instr_count), 0);

    // single-step: held request runs exactly one instruction
    b.step_mode = 1'b1;
    b.step_req  = 1'b0;
    b.opcode    = 4'd0;
    reset       = 1'b0;
    tick();
    chk("s_idle", 32'(b.estado), 0);
    b.step_req = 1'b1;
    tick();
    chk("s_fetch", 32'(b.estado), 1);
    for (int i = 0; i < 19; i++) tick();
    chk("s_back_idle", 32'(b.estado), 0);
    chk("s_count_1", 32'(b.instr_count), 1);
    b.step_req = 1'b0;
    tick();
    b.step_req = 1'b1;
    tick();
    chk("s2_fetch", 32'(b.estado), 1);
    tick();
    tick();
    chk("s2_exec", 32'(b.estado), 3);
    b.step_req = 1'b0;
    tick();
    b.step_req = 1'b1;
    tick();
    tick();
    chk("s_drop_idle", 32'(b.estado), 0);
    chk("s_count_2", 32'(b.instr_count), 2);

    // reset asserted during WB
    b.step_mode = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("rwb_in_wb", 32'(b.esc_reg), 1);
    reset = 1'b1;
    #1;
    chk("rwb_esc_reg", 32'(b.esc_reg), 0);
    chk("rwb_esc_cp", 32'(b.esc_cp), 0);
    tick();
    chk("rwb_estado", 32'(b.estado), 0);
    chk("rwb_count", 32'(b.instr_count), 0);

    // counter wrap on the 2-bit instance using NOPs
    b.opcode = 4'd13;
    reset    = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("wrap_ones", 32'(bs.instr_count), 3);
    tick();
    tick();
    chk("wrap_zero", 32'(bs.instr_count), 0);
    chk("wrap_big", 32'(b.instr_count), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
